// File: rtl/rs_dec_pkg.sv
// Shared definitions for the RS decoder codeword-buffer read side:
// geometry constants, the reader FSM state type, the FIFO entry layout
// and the modulo-DEPTH address helper.
package rs_dec_pkg;

    localparam int SYM_W  = 8;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 264;
    localparam int N_SYMB = 255;
    localparam int T_ERR  = 8;
    localparam int K      = N_SYMB - 2 * T_ERR;
    localparam int FIFO_D = 4;

    localparam int IDX_W   = 8;
    localparam int CNT_W   = $clog2(FIFO_D + 1);
    localparam int TAB_W   = $clog2(T_ERR);
    localparam int ERR_C_W = $clog2(T_ERR + 1);
    localparam int ENTRY_W = SYM_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    // One FIFO entry: framing flags travel with the corrected symbol.
    typedef struct packed {
        logic             sop;
        logic             eop;
        logic [SYM_W-1:0] data;
    } entry_t;

    // base + idx folded back into the RAM; base < DEPTH and idx < DEPTH,
    // so one conditional subtraction is enough.
    function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] base,
                                                   input logic [IDX_W-1:0]  idx);
        logic [ADDR_W:0] sum;
        sum = {1'b0, base} + {{(ADDR_W + 1 - IDX_W){1'b0}}, idx};
        if (sum >= (ADDR_W + 1)'(DEPTH))
            sum = sum - (ADDR_W + 1)'(DEPTH);
        return sum[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/rs_rdr_out_fifo.sv
// Small show-ahead FIFO between the RAM return path and the output port.
// The head entry is presented combinationally; count feeds the issue credit.
module rs_rdr_out_fifo
    import rs_dec_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               valid,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = $clog2(FIFO_D);

    logic [ENTRY_W-1:0] mem [FIFO_D];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage write.
    // NOTE: the data array has no reset; pointers and count alone define
    // what is valid, and the head is masked to zero when empty.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_next(wr_ptr);
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign valid   = (count != '0);
    assign rd_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/rs_decode_ram_reader.sv
// Read side of the RS decoder codeword buffer: issues credit-limited reads
// from the dual-port RAM, XORs error magnitudes into located symbols and
// streams the corrected codeword out with backpressure.
// Optional macro RS_RDR_PARITY_STRIP_EN: output only the K data symbols.
module rs_decode_ram_reader
    import rs_dec_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              dec_fail,
    input  logic              err_valid,
    input  logic [7:0]        err_loc,
    input  logic [7:0]        err_mag,
    output logic [ADDR_W-1:0] rdaddress,
    output logic              rden,
    input  logic [SYM_W-1:0]  q,
    output logic [SYM_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_fail,
    output logic              busy,
    output logic              done
);

`ifdef RS_RDR_PARITY_STRIP_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SYMB - 1);
`endif

    state_t              state;
    logic [ADDR_W-1:0]   base_q;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    rd_idx;
    logic                s1_valid, s2_valid;
    logic [IDX_W-1:0]    s1_idx, s2_idx;

    logic [IDX_W-1:0]    loc_tab [T_ERR];
    logic [SYM_W-1:0]    mag_tab [T_ERR];
    logic [ERR_C_W-1:0]  err_cnt;
    logic                err_load;
    logic [SYM_W-1:0]    corr;

    logic                pop;
    logic                frame_end;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W:0]      occ;
    logic                credit_ok;
    entry_t              wr_entry;
    entry_t              rd_entry;

    assign pop       = out_valid & out_ready;
    assign frame_end = (state == DRAIN) & pop & out_eop;
    assign err_load  = (state == IDLE) & err_valid & (err_cnt < ERR_C_W'(T_ERR));

    // Occupancy as it will stand next cycle if nothing new is issued:
    // queued symbols plus every read still in the RAM pipeline.
    assign occ = {1'b0, fifo_count} + (CNT_W + 1)'(rden) + (CNT_W + 1)'(s1_valid)
               + (CNT_W + 1)'(s2_valid) - (CNT_W + 1)'(pop);
    assign credit_ok = (occ < (CNT_W + 1)'(FIFO_D));

    // Reader FSM with registered RAM-side and status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            base_q    <= '0;
            idx       <= '0;
            rd_idx    <= '0;
            rden      <= 1'b0;
            rdaddress <= '0;
            out_fail  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rden <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= READ;
                        base_q    <= base_addr;
                        out_fail  <= dec_fail;
                        busy      <= 1'b1;
                        rden      <= 1'b1;
                        rdaddress <= base_addr;
                        rd_idx    <= '0;
                        idx       <= IDX_W'(1);
                    end
                end
                READ: begin
                    if (credit_ok) begin
                        rden      <= 1'b1;
                        rdaddress <= wrap_add(base_q, idx);
                        rd_idx    <= idx;
                        if (idx == LAST_IDX)
                            state <= DRAIN;
                        else
                            idx <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (frame_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage tracker aligning each read's index with its RAM data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_idx   <= '0;
            s2_idx   <= '0;
        end else begin
            s1_valid <= rden;
            s2_valid <= s1_valid;
            s1_idx   <= rd_idx;
            s2_idx   <= s1_idx;
        end
    end

    // Correction-table fill count; cleared when the frame completes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            err_cnt <= '0;
        else if (frame_end)
            err_cnt <= '0;
        else if (err_load)
            err_cnt <= err_cnt + 1'b1;
    end

    // Correction-table entries; only the first err_cnt are ever consulted.
    always_ff @(posedge clock) begin
        if (err_load) begin
            loc_tab[err_cnt[TAB_W-1:0]] <= err_loc;
            mag_tab[err_cnt[TAB_W-1:0]] <= err_mag;
        end
    end

    // XOR of every loaded magnitude whose location matches the returning index.
    // NOTE: combinational accumulation uses blocking '=' and starts from a
    // default so no latch is inferred; clocked state elsewhere uses '<='.
    always_comb begin
        corr = '0;
        for (int i = 0; i < T_ERR; i++) begin
            if ((ERR_C_W'(i) < err_cnt) && (loc_tab[i] == s2_idx))
                corr = corr ^ mag_tab[i];
        end
    end

    assign wr_entry.sop  = (s2_idx == '0);
    assign wr_entry.eop  = (s2_idx == LAST_IDX);
    assign wr_entry.data = out_fail ? q : (q ^ corr);

    rs_rdr_out_fifo u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (s2_valid),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .valid   (out_valid),
        .count   (fifo_count)
    );

    assign out_sop  = rd_entry.sop;
    assign out_eop  = rd_entry.eop;
    assign out_data = rd_entry.data;

endmodule

// File: tb/tb_rs_decode_ram_reader.sv
// Directed bench for rs_decode_ram_reader: a table of codeword scenarios
// with hand-computed spot values, a RAM model with 2-cycle read latency,
// a scoreboard of transferred symbols and protocol monitors.
module tb_rs_decode_ram_reader;

    localparam int DEPTH  = 264;
    localparam int FIFO_D = 4;
`ifdef RS_RDR_PARITY_STRIP_EN
    localparam int EXP_LEN = 239;
`else
    localparam int EXP_LEN = 255;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [8:0] base_addr = '0;
    logic       dec_fail = 1'b0;
    logic       err_valid = 1'b0;
    logic [7:0] err_loc = '0;
    logic [7:0] err_mag = '0;
    logic [8:0] rdaddress;
    logic       rden;
    logic [7:0] q = '0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_sop, out_eop, out_fail, busy, done;

    rs_decode_ram_reader dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .dec_fail  (dec_fail),
        .err_valid (err_valid),
        .err_loc   (err_loc),
        .err_mag   (err_mag),
        .rdaddress (rdaddress),
        .rden      (rden),
        .q         (q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_fail  (out_fail),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // RAM contents and the 2-cycle registered read model.
    function automatic logic [7:0] ram_val(input int a);
        return 8'((a * 7 + 3) % 256);
    endfunction

    logic [7:0] ram_p1;
    logic       ram_v1;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            ram_v1 <= 1'b0;
        end else begin
            ram_v1 <= rden;
            if (rden)
                ram_p1 <= ram_val(int'(rdaddress));
            if (ram_v1)
                q <= ram_p1;
        end
    end

    typedef struct packed {
        logic [8:0]      base;
        logic            fail;
        logic            rnd;
        logic            mid;
        logic            lws;
        logic [3:0]      nerr;
        logic [8:0][7:0] loc;
        logic [8:0][7:0] mag;
        logic [1:0][7:0] spot_idx;
        logic [1:0][7:0] spot_val;
    } vec_t;

    vec_t vecs [7];

    task automatic set_vec(input int i, input int base, input bit fail, input bit rnd,
                           input bit mid, input bit lws, input int si0, input int sv0,
                           input int si1, input int sv1);
        vecs[i]             = '0;
        vecs[i].base        = 9'(base);
        vecs[i].fail        = fail;
        vecs[i].rnd         = rnd;
        vecs[i].mid         = mid;
        vecs[i].lws         = lws;
        vecs[i].spot_idx[0] = 8'(si0);
        vecs[i].spot_val[0] = 8'(sv0);
        vecs[i].spot_idx[1] = 8'(si1);
        vecs[i].spot_val[1] = 8'(sv1);
    endtask

    task automatic add_err(input int i, input int loc, input int mag);
        vecs[i].loc[vecs[i].nerr] = 8'(loc);
        vecs[i].mag[vecs[i].nerr] = 8'(mag);
        vecs[i].nerr              = vecs[i].nerr + 4'd1;
    endtask

    // Reference: RAM symbol at the wrapped address, XORed with the first
    // T_ERR(=8) loaded entries that match, unless the decoder failed.
    function automatic logic [7:0] exp_sym(input vec_t v, input int k);
        logic [7:0] s;
        s = ram_val((int'(v.base) + k) % DEPTH);
        if (!v.fail)
            for (int j = 0; j < int'(v.nerr) && j < 8; j++)
                if (int'(v.loc[j]) == k)
                    s = s ^ v.mag[j];
        return s;
    endfunction

    // Monitor state.
    logic [7:0] got_data [$];
    bit         got_sop  [$];
    bit         got_eop  [$];
    bit         mon_en = 1'b0;
    int         cur_base;
    bit         cur_fail;
    int rd_cnt, issued, xferred, credit_viol, addr_viol, stab_viol, fail_viol;
    int done_cnt, done_cyc, first_valid_cyc, first_xfer_cyc, last_xfer_cyc;
    bit         prev_stall;
    logic [9:0] prev_out;

    task automatic clear_mon();
        got_data.delete(); got_sop.delete(); got_eop.delete();
        rd_cnt = 0; issued = 0; xferred = 0; credit_viol = 0; addr_viol = 0;
        stab_viol = 0; fail_viol = 0; done_cnt = 0; done_cyc = -1;
        first_valid_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1;
        prev_stall = 1'b0; prev_out = '0;
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (rden) begin
                if (int'(rdaddress) >= DEPTH) addr_viol++;
                if (int'(rdaddress) != (cur_base + rd_cnt) % DEPTH) addr_viol++;
                if (issued - xferred >= FIFO_D) credit_viol++;
                rd_cnt++;
                issued++;
            end
            if (prev_stall && (!out_valid || {out_sop, out_eop, out_data} !== prev_out))
                stab_viol++;
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_sop, out_eop, out_data};
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_fail !== cur_fail) fail_viol++;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_sop.push_back(out_sop);
                got_eop.push_back(out_eop);
                if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
                xferred++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic run_frame(input int vi);
        vec_t v;
        int   n_pre, s_cyc, mism, sop_bad, eop_bad;
        bit   timed_out;
        logic [31:0] spot_act;
        v = vecs[vi];
        clear_mon();
        cur_base = int'(v.base);
        cur_fail = v.fail;
        mon_en   = 1'b1;
        n_pre = v.lws ? int'(v.nerr) - 1 : int'(v.nerr);
        for (int j = 0; j < n_pre; j++) begin
            @(posedge clock); #1;
            err_valid = 1'b1; err_loc = v.loc[j]; err_mag = v.mag[j];
        end
        @(posedge clock); #1;
        err_valid = v.lws;
        if (v.lws) begin
            err_loc = v.loc[v.nerr - 1];
            err_mag = v.mag[v.nerr - 1];
        end
        start = 1'b1; base_addr = v.base; dec_fail = v.fail;
        out_ready = v.rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
        s_cyc = cyc;
        timed_out = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clock); #1;
            start = 1'b0; err_valid = 1'b0;
            if (v.mid && c == 20) begin
                start = 1'b1; base_addr = 9'd5; dec_fail = 1'b0;
                err_valid = 1'b1; err_loc = 8'd10; err_mag = 8'hFF;
            end
            out_ready = v.rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (done_cnt > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clock); #1;
        end
        mon_en = 1'b0;

        mism = 0; sop_bad = 0; eop_bad = 0;
        for (int k = 0; k < got_data.size(); k++) begin
            if (got_data[k] !== exp_sym(v, k)) mism++;
            if (got_sop[k] != (k == 0)) sop_bad++;
            if (got_eop[k] != (k == EXP_LEN - 1)) eop_bad++;
        end
        check($sformatf("v%0d timeout", vi), 32'(timed_out), 0);
        check($sformatf("v%0d length", vi), got_data.size(), EXP_LEN);
        check($sformatf("v%0d data mismatches", vi), mism, 0);
        check($sformatf("v%0d sop placement", vi), sop_bad, 0);
        check($sformatf("v%0d eop placement", vi), eop_bad, 0);
        for (int s = 0; s < 2; s++) begin
            spot_act = (int'(v.spot_idx[s]) < got_data.size()) ? 32'(got_data[v.spot_idx[s]]) : 32'h1FF;
            check($sformatf("v%0d symbol %0d", vi, v.spot_idx[s]), spot_act, 32'(v.spot_val[s]));
        end
        check($sformatf("v%0d out_fail", vi), fail_viol, 0);
        check($sformatf("v%0d done pulses", vi), done_cnt, 1);
        check($sformatf("v%0d done after eop", vi), done_cyc - last_xfer_cyc, 1);
        check($sformatf("v%0d addresses", vi), addr_viol, 0);
        check($sformatf("v%0d read count", vi), rd_cnt, EXP_LEN);
        check($sformatf("v%0d credit", vi), credit_viol, 0);
        check($sformatf("v%0d hold stable", vi), stab_viol, 0);
        check($sformatf("v%0d busy after", vi), 32'(busy), 0);
        if (!v.rnd) begin
            check($sformatf("v%0d latency", vi), first_valid_cyc - s_cyc, 4);
            check($sformatf("v%0d throughput", vi), last_xfer_cyc - first_xfer_cyc, EXP_LEN - 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Scenario table; spot values are (a*7+3) mod 256 at the wrapped
        // address, XORed by hand with the applicable magnitudes.
        set_vec(0, 0,   0, 0, 0, 0,   0, 'h03, 200, 'h7B);
        set_vec(1, 0,   0, 0, 0, 0, 100, 'hE5,   0, 'hFC);
        add_err(1, 0, 'hFF); add_err(1, 100, 'h5A); add_err(1, 254, 'h01);
        set_vec(2, 0,   0, 0, 0, 1, 100, 'hBF,   0, 'hFC);
        add_err(2, 0, 'hFF); add_err(2, 100, 'h5A); add_err(2, 254, 'h01); add_err(2, 100, 'h5A);
        set_vec(3, 200, 0, 0, 0, 0,  63, 'h34,  64, 'h03);
        set_vec(4, 200, 0, 1, 0, 0,   5, 'h8F,  70, 'hAD);
        add_err(4, 5, 'h11); add_err(4, 70, 'h80);
        set_vec(5, 0,   1, 0, 1, 0,   0, 'h03,   3, 'h18);
        add_err(5, 0, 'hFF); add_err(5, 3, 'h0F);
        set_vec(6, 0,   0, 0, 0, 0,   8, 'h3A,   9, 'h42);
        for (int j = 1; j <= 9; j++) add_err(6, j, 'h01);

        clear_mon();
        #13;
        check("reset rden", 32'(rden), 0);
        check("reset out_valid", 32'(out_valid), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset rdaddress", 32'(rdaddress), 0);
        @(posedge clock); #1;
        reset = 1'b1;

        for (int i = 0; i < 7; i++) run_frame(i);

        // Abort a failing frame mid-stream with reset.
        clear_mon();
        cur_base = 0; cur_fail = 1'b1; mon_en = 1'b1;
        @(posedge clock); #1;
        start = 1'b1; base_addr = '0; dec_fail = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
        end
        check("pre-abort busy", 32'(busy), 1);
        check("pre-abort out_fail", 32'(out_fail), 1);
        reset = 1'b0;
        #1;
        check("abort rden", 32'(rden), 0);
        check("abort rdaddress", 32'(rdaddress), 0);
        check("abort out_valid", 32'(out_valid), 0);
        check("abort out_data", 32'(out_data), 0);
        check("abort out_sop", 32'(out_sop), 0);
        check("abort out_eop", 32'(out_eop), 0);
        check("abort out_fail", 32'(out_fail), 0);
        check("abort busy", 32'(busy), 0);
        repeat (3) begin
            @(posedge clock); #1;
        end
        check("abort no done", done_cnt, 0);
        mon_en = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        run_frame(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
